galaga_rom_loader: RTL and testbench
====================================

Name: galaga_rom_loader

Overview:
Sequences the HPS ioctl ROM download into the Galaga core's ROM write port and owns the core reset.
- Decodes the linear download address into one of four ROM regions and emits registered per-region write strobes.
- Counts accepted bytes and validates the image length.
- Holds the core in reset until a complete image is loaded, then for a settle window afterwards.
- Sits in the top-level between hps_io and the galaga core, replacing the direct ioctl→dn_* wiring and the ioctl_download term in the core reset.

Parameters:
REG0_END, 17'h04000, exclusive end of region 0 (main CPU ROM)
REG1_END, 17'h05000, exclusive end of region 1 (sub CPU ROM)
REG2_END, 17'h06000, exclusive end of region 2 (sound CPU ROM)
TOTAL_SIZE, 17'h10000, exclusive end of region 3 (gfx/PROMs); required image length
SETTLE_CYCLES, 1024, core-reset hold after load or user reset, in clk_sys cycles (≥2)

Ports:
clk_sys  in  1  system clock (18 MHz domain of hps_io)
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  download window, level
ioctl_wr  in  1  byte strobe, one clk_sys pulse
ioctl_addr  in  25  byte address
ioctl_dout  in  8  byte data
user_reset  in  1  menu/button reset request, level
dn_addr  out  17  registered address to core
dn_data  out  8  registered data to core
dn_wr  out  1  registered write pulse to core
rom_we  out  4  one-hot region strobe, coincident with dn_wr
core_reset  out  1  reset to galaga core, active high
rom_ok  out  1  last download complete and valid
dl_overflow  out  1  write beyond TOTAL_SIZE seen in current/last download
byte_count  out  17  accepted bytes in current/last download (saturates at 17'h1FFFF)

Behaviour:
- Reset (async, reset_n=0):
  - state=WAIT_DL; core_reset=1; dn_wr=0; rom_we=0; dn_addr=0; dn_data=0.
  - rom_ok=0; dl_overflow=0; byte_count=0; settle counter=0.
- Download-edge detect uses a registered copy of ioctl_download; the rising edge is the cycle ioctl_download=1 and the copy=0.
- Write acceptance, 1-cycle latency:
  - A write is accepted iff state=LOAD, ioctl_wr=1, ioctl_addr[24:17]==0 and ioctl_addr[16:0]<TOTAL_SIZE.
  - Next cycle: dn_wr=1, dn_addr=ioctl_addr[16:0], dn_data=ioctl_dout, rom_we one-hot:
    - bit0 if addr<REG0_END
    - bit1 if addr<REG1_END
    - bit2 if addr<REG2_END
    - bit3 otherwise
  - Otherwise dn_wr=0 and rom_we=0; dn_addr and dn_data hold their values.
  - Accepted write: byte_count+1, saturating at 17'h1FFFF.
  - Write in LOAD but out of range: dropped, dl_overflow=1.
  - ioctl_wr outside LOAD: ignored, no count change, no flag.
- States:
  - WAIT_DL: core_reset=1.
    - Rising edge of ioctl_download → LOAD.
  - LOAD: core_reset=1.
    - On entry: byte_count=0, dl_overflow=0, rom_ok=0.
    - ioctl_download=0 → evaluate. A write accepted in the same cycle as the fall is counted first, so the compare uses the updated count.
    - If byte_count≥TOTAL_SIZE and dl_overflow=0: rom_ok=1 → SETTLE.
    - Else: rom_ok=0 → WAIT_DL.
  - SETTLE: core_reset=1.
    - Counter loads SETTLE_CYCLES-1 on entry and decrements each cycle.
    - At 0 → RUN.
    - Rising edge of ioctl_download → LOAD (abort).
    - user_reset has no extra effect; the counter is not restarted.
  - RUN: core_reset=0.
    - Rising edge of ioctl_download → LOAD; core_reset=1 from the next cycle.
    - Else user_reset=1 → SETTLE.
    - Download has priority when both occur in the same cycle.
- core_reset is a registered decode of the state: asserted the cycle after entering LOAD/SETTLE, deasserted the cycle after entering RUN.
- A new download always invalidates rom_ok; the core never runs on a partial image.
- reset_n asserted mid-LOAD: immediate return to reset values; no partial write is issued after reset_n falls.

Test Plan:
- Power-up: reset_n low 5 cycles then high, no download, 10k cycles → core_reset=1 throughout, rom_ok=0, dn_wr never 1.
- Full load: download=1, 65536 writes addr 0..FFFF, data=addr[7:0], then download=0.
  - dn_wr per write, 1 cycle after ioctl_wr; rom_we=0001 for addr 3FFF, 0010 for 4000, 0100 for 5FFF, 1000 for 6000.
  - byte_count=65536, rom_ok=1, core_reset falls exactly SETTLE_CYCLES+1 cycles after the download fall.
- Short image: 1000 writes then download=0 → rom_ok=0, state WAIT_DL, core_reset stays 1.
- Overflow: full load plus one write to addr 10000 → no dn_wr for it, dl_overflow=1, rom_ok=0, core_reset stays 1.
- Edge cases:
  - Last write coincident with the download fall → counted, rom_ok=1.
  - In RUN, user_reset and download rise together → LOAD entered, rom_ok=0.
  - user_reset pulse alone in RUN → core_reset high for SETTLE_CYCLES+1 cycles.
- Async reset: reset_n low at write 30000 of a load → outputs at reset values in the same cycle; a subsequent full load succeeds.

Source files
------------

// File: rtl/galaga_rom_loader.sv
// galaga_rom_loader: routes the hps_io ioctl ROM download into the Galaga
// core's ROM write port, tracks image length/overflow, and owns core reset.
module galaga_rom_loader #(
   parameter logic [16:0] REG0_END      = 17'h04000,
   parameter logic [16:0] REG1_END      = 17'h05000,
   parameter logic [16:0] REG2_END      = 17'h06000,
   parameter logic [16:0] TOTAL_SIZE    = 17'h10000,
   parameter int unsigned SETTLE_CYCLES = 1024
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        user_reset,
   output logic [16:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic [3:0]  rom_we,
   output logic        core_reset,
   output logic        rom_ok,
   output logic        dl_overflow,
   output logic [16:0] byte_count
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {WAIT_DL, LOAD, SETTLE, RUN} state_t;

   state_t           state_q, state_d;
   logic             dl_q, dl_d;
   logic [16:0]      dn_addr_q, dn_addr_d;
   logic [7:0]       dn_data_q, dn_data_d;
   logic             dn_wr_q, dn_wr_d;
   logic [3:0]       rom_we_q, rom_we_d;
   logic             core_reset_q, core_reset_d;
   logic             rom_ok_q, rom_ok_d;
   logic             dl_overflow_q, dl_overflow_d;
   logic [16:0]      byte_count_q, byte_count_d;
   logic [CNT_W-1:0] settle_q, settle_d;

   logic dl_rise;
   logic in_range;
   logic wr_accept;

   // Next-state: write acceptance/decode, length bookkeeping and FSM sequencing.
   always_comb begin
      state_d       = state_q;
      dl_d          = ioctl_download;
      dn_addr_d     = dn_addr_q;
      dn_data_d     = dn_data_q;
      dn_wr_d       = 1'b0;
      rom_we_d      = '0;
      rom_ok_d      = rom_ok_q;
      dl_overflow_d = dl_overflow_q;
      byte_count_d  = byte_count_q;
      settle_d      = settle_q;

      dl_rise   = ioctl_download & ~dl_q;
      in_range  = (ioctl_addr[24:17] == '0) && (ioctl_addr[16:0] < TOTAL_SIZE);
      wr_accept = (state_q == LOAD) && ioctl_wr && in_range;

      if (wr_accept) begin
         dn_wr_d   = 1'b1;
         dn_addr_d = ioctl_addr[16:0];
         dn_data_d = ioctl_dout;
         if (ioctl_addr[16:0] < REG0_END)      rom_we_d = 4'b0001;
         else if (ioctl_addr[16:0] < REG1_END) rom_we_d = 4'b0010;
         else if (ioctl_addr[16:0] < REG2_END) rom_we_d = 4'b0100;
         else                                  rom_we_d = 4'b1000;
         if (byte_count_q != '1) byte_count_d = byte_count_q + 17'd1;
      end else if ((state_q == LOAD) && ioctl_wr) begin
         dl_overflow_d = 1'b1;
      end

      case (state_q)
         WAIT_DL: begin
            if (dl_rise) begin
               state_d       = LOAD;
               byte_count_d  = '0;
               dl_overflow_d = 1'b0;
               rom_ok_d      = 1'b0;
            end
         end
         LOAD: begin
            // Evaluation uses the _d values so a write landing with the fall is included.
            if (!ioctl_download) begin
               if ((byte_count_d >= TOTAL_SIZE) && !dl_overflow_d) begin
                  rom_ok_d = 1'b1;
                  state_d  = SETTLE;
                  settle_d = SETTLE_LOAD;
               end else begin
                  rom_ok_d = 1'b0;
                  state_d  = WAIT_DL;
               end
            end
         end
         SETTLE: begin
            if (dl_rise) begin
               state_d       = LOAD;
               byte_count_d  = '0;
               dl_overflow_d = 1'b0;
               rom_ok_d      = 1'b0;
            end else if (settle_q == '0) begin
               state_d = RUN;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         RUN: begin
            if (dl_rise) begin
               state_d       = LOAD;
               byte_count_d  = '0;
               dl_overflow_d = 1'b0;
               rom_ok_d      = 1'b0;
            end else if (user_reset) begin
               state_d  = SETTLE;
               settle_d = SETTLE_LOAD;
            end
         end
         default: state_d = WAIT_DL;
      endcase

      core_reset_d = (state_q != RUN);
   end

   // State and registered outputs, cleared asynchronously by reset_n.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= WAIT_DL;
         dl_q          <= 1'b0;
         dn_addr_q     <= '0;
         dn_data_q     <= '0;
         dn_wr_q       <= 1'b0;
         rom_we_q      <= '0;
         core_reset_q  <= 1'b1;
         rom_ok_q      <= 1'b0;
         dl_overflow_q <= 1'b0;
         byte_count_q  <= '0;
         settle_q      <= '0;
      end else begin
         state_q       <= state_d;
         dl_q          <= dl_d;
         dn_addr_q     <= dn_addr_d;
         dn_data_q     <= dn_data_d;
         dn_wr_q       <= dn_wr_d;
         rom_we_q      <= rom_we_d;
         core_reset_q  <= core_reset_d;
         rom_ok_q      <= rom_ok_d;
         dl_overflow_q <= dl_overflow_d;
         byte_count_q  <= byte_count_d;
         settle_q      <= settle_d;
      end
   end

   assign dn_addr     = dn_addr_q;
   assign dn_data     = dn_data_q;
   assign dn_wr       = dn_wr_q;
   assign rom_we      = rom_we_q;
   assign core_reset  = core_reset_q;
   assign rom_ok      = rom_ok_q;
   assign dl_overflow = dl_overflow_q;
   assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_galaga_rom_loader.sv
// Directed bench for galaga_rom_loader with a write scoreboard (scaled ROM map).
module tb_galaga_rom_loader;

   localparam logic [16:0] R0   = 17'h00100;
   localparam logic [16:0] R1   = 17'h00140;
   localparam logic [16:0] R2   = 17'h00180;
   localparam logic [16:0] TS   = 17'h00200;
   localparam int unsigned NSET = 16;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        user_reset;
   logic [16:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic [3:0]  rom_we;
   logic        core_reset;
   logic        rom_ok;
   logic        dl_overflow;
   logic [16:0] byte_count;

   typedef struct packed {
      logic [16:0] a;
      logic [7:0]  d;
      logic [3:0]  we;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;
   int  checks = 0;
   int  errors = 0;

   galaga_rom_loader #(
      .REG0_END(R0), .REG1_END(R1), .REG2_END(R2),
      .TOTAL_SIZE(TS), .SETTLE_CYCLES(NSET)
   ) dut (
      .clk_sys(clk), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .user_reset(user_reset),
      .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .rom_we(rom_we),
      .core_reset(core_reset), .rom_ok(rom_ok), .dl_overflow(dl_overflow),
      .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] exp_we(input logic [16:0] a);
      if (a < R0) return 4'b0001;
      if (a < R1) return 4'b0010;
      if (a < R2) return 4'b0100;
      return 4'b1000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit accept);
      wr_t e;
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (accept) begin
         e.a  = a[16:0];
         e.d  = d;
         e.we = exp_we(a[16:0]);
         sb.push_back(e);
      end
      tick(1);
      ioctl_wr = 1'b0;
   endtask

   // Ends one ns after the edge that samples the download fall.
   task automatic load(input int unsigned nbytes, input bit coincident);
      ioctl_download = 1'b1;
      tick(1);
      for (int unsigned i = 0; i < nbytes; i++) begin
         if (coincident && (i == nbytes - 1)) ioctl_download = 1'b0;
         wr(25'(i), 8'(i), 1'b1);
      end
      if (!coincident) begin
         ioctl_download = 1'b0;
         tick(1);
      end
   endtask

   // Counts edges after the current one until core_reset drops (bounded).
   task automatic wait_fall(output int k);
      k = 0;
      while ((core_reset !== 1'b0) && (k < 4 * NSET)) begin
         tick(1);
         k++;
      end
   endtask

   task automatic hold_high(input string tag, input int n);
      int lows;
      lows = 0;
      repeat (n) begin
         tick(1);
         if (core_reset !== 1'b1) lows++;
      end
      chk(tag, 32'(lows), 32'd0);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_core_reset"}, 32'(core_reset), 32'd1);
      chk({pfx, "_dn_wr"}, 32'(dn_wr), 32'd0);
      chk({pfx, "_rom_we"}, 32'(rom_we), 32'd0);
      chk({pfx, "_dn_addr"}, 32'(dn_addr), 32'd0);
      chk({pfx, "_dn_data"}, 32'(dn_data), 32'd0);
      chk({pfx, "_rom_ok"}, 32'(rom_ok), 32'd0);
      chk({pfx, "_overflow"}, 32'(dl_overflow), 32'd0);
      chk({pfx, "_byte_count"}, 32'(byte_count), 32'd0);
   endtask

   // Scoreboard consumer: every dn_wr must match the oldest accepted write.
   always @(negedge clk) begin
      if (dn_wr === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed addr=%0h expected no write", dn_addr);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("dn_addr", 32'(dn_addr), 32'(mon_e.a));
            chk("dn_data", 32'(dn_data), 32'(mon_e.d));
            chk("rom_we", 32'(rom_we), 32'(mon_e.we));
         end
      end else begin
         chk("rom_we_idle", 32'(rom_we), 32'd0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int hi;

      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      user_reset     = 1'b0;
      tick(5);
      chk_reset_vals("por");
      reset_n = 1'b1;

      // Idle with no download; stray writes must be ignored.
      wr(25'h10, 8'hAA, 1'b0);
      hold_high("idle_core_reset", 200);
      wr(25'h20, 8'hBB, 1'b0);
      chk("idle_rom_ok", 32'(rom_ok), 32'd0);
      chk("idle_byte_count", 32'(byte_count), 32'd0);
      chk("idle_overflow", 32'(dl_overflow), 32'd0);

      // Full load, last write coincident with the download fall.
      load(TS, 1'b1);
      chk("full1_rom_ok", 32'(rom_ok), 32'd1);
      chk("full1_byte_count", 32'(byte_count), 32'(TS));
      chk("full1_overflow", 32'(dl_overflow), 32'd0);
      chk("full1_core_reset", 32'(core_reset), 32'd1);
      wait_fall(k);
      chk("full1_settle_len", 32'(k), 32'(NSET + 1));
      chk("full1_sb_empty", 32'(sb.size()), 32'd0);

      // user_reset held for a few cycles in RUN: settle is not restarted.
      user_reset = 1'b1;
      tick(1);
      chk("ures_core_reset_lag", 32'(core_reset), 32'd0);
      k  = 0;
      hi = 0;
      while (!((hi > 0) && (core_reset === 1'b0)) && (k < 4 * NSET)) begin
         tick(1);
         k++;
         if (k == 3) user_reset = 1'b0;
         if (core_reset === 1'b1) hi++;
      end
      chk("ures_settle_len", 32'(k), 32'(NSET + 1));
      chk("ures_rom_ok", 32'(rom_ok), 32'd1);

      // Short image from RUN.
      load(100, 1'b0);
      chk("short_rom_ok", 32'(rom_ok), 32'd0);
      chk("short_byte_count", 32'(byte_count), 32'd100);
      chk("short_core_reset", 32'(core_reset), 32'd1);
      wr(25'h5, 8'h12, 1'b0);
      hold_high("short_core_reset_hold", NSET + 5);

      // Overflow: full image plus out-of-range writes.
      ioctl_download = 1'b1;
      tick(1);
      for (int unsigned i = 0; i < TS; i++) wr(25'(i), 8'(i), 1'b1);
      wr(25'(TS), 8'h55, 1'b0);
      wr(25'h0100010, 8'h66, 1'b0);
      ioctl_download = 1'b0;
      tick(1);
      chk("ovf_flag", 32'(dl_overflow), 32'd1);
      chk("ovf_rom_ok", 32'(rom_ok), 32'd0);
      chk("ovf_byte_count", 32'(byte_count), 32'(TS));
      hold_high("ovf_core_reset_hold", NSET + 5);
      chk("ovf_sb_empty", 32'(sb.size()), 32'd0);

      // Clean load, then download rise together with user_reset in RUN.
      load(TS, 1'b0);
      chk("full2_rom_ok", 32'(rom_ok), 32'd1);
      wait_fall(k);
      chk("full2_settle_len", 32'(k), 32'(NSET + 1));
      user_reset     = 1'b1;
      ioctl_download = 1'b1;
      tick(1);
      chk("both_rom_ok", 32'(rom_ok), 32'd0);
      chk("both_byte_count", 32'(byte_count), 32'd0);
      chk("both_core_reset_lag", 32'(core_reset), 32'd0);
      user_reset = 1'b0;
      tick(1);
      chk("both_core_reset", 32'(core_reset), 32'd1);

      // Async reset in the middle of that load.
      for (int unsigned i = 0; i < 32'h120; i++) wr(25'(i), 8'(i ^ 32'h5A), 1'b1);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h120;
      ioctl_dout = 8'hC3;
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      sb.delete();
      ioctl_wr       = 1'b0;
      ioctl_download = 1'b0;
      tick(2);
      reset_n = 1'b1;
      tick(2);

      load(TS, 1'b1);
      chk("full3_rom_ok", 32'(rom_ok), 32'd1);
      chk("full3_byte_count", 32'(byte_count), 32'(TS));
      wait_fall(k);
      chk("full3_settle_len", 32'(k), 32'(NSET + 1));
      tick(3);
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
